// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, bubble word, fetch FSM states and IF/ID payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  function automatic logic [OP_W-1:0] opcode(input logic [XLEN-1:0] inst);
    return inst[31:26];
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select for the fetch stage: branch beats jump, otherwise sequential PC+4.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [3:0]      i_pc4_hi,
  input  logic [25:0]     i_jump_index,
  input  logic [29:0]     i_branch_target_hi,
  input  logic            i_branch,
  input  logic            i_jump,
  output logic [XLEN-1:0] o_next_pc_c,
  output logic            o_redirect_c
);

  logic [XLEN-1:0] w_jump_target;

  assign w_jump_target = {i_pc4_hi, i_jump_index, 2'b00};

  always_comb begin
    o_redirect_c = i_branch | i_jump;
    o_next_pc_c  = i_pc + 32'd4;
    if (i_branch) begin
      o_next_pc_c = {i_branch_target_hi, 2'b00};
    end else if (i_jump) begin
      o_next_pc_c = w_jump_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ready handshake, IF/ID register, redirect and squash.
// Optional FETCH_PERF_EN adds saturating fetch/squash event counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [5:0]  op_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_squash_o
`endif
);

  import mips_pkg::*;

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_squash, w_squash_nxt;
  logic            r_req;
  ifid_t           r_ifid, w_ifid_nxt;
  logic            r_ifid_valid, w_ifid_valid_nxt;
  ifid_t           r_hold, w_hold_nxt;

  logic [XLEN-1:0] w_next_pc_c;
  logic            w_redirect_c;
  logic            w_redirect;
  logic            w_accept;
  logic            w_deliver;
  logic [XLEN-1:0] w_pc4;

  fetch_next_pc u_next_pc (
    .i_pc               (r_pc),
    .i_pc4_hi           (r_ifid.pc4[31:28]),
    .i_jump_index       (r_ifid.inst[25:0]),
    .i_branch_target_hi (branch_target_i[31:2]),
    .i_branch           (branch_i),
    .i_jump             (jump_i),
    .o_next_pc_c        (w_next_pc_c),
    .o_redirect_c       (w_redirect_c)
  );

  // IDLE ignores redirects; a return is only usable when neither squashed nor redirected
  assign w_redirect = w_redirect_c && (r_state != IDLE);
  assign w_accept   = (r_state == FETCH) && imem_ready_i;
  assign w_deliver  = w_accept && !r_squash && !w_redirect;
  assign w_pc4      = r_pc + 32'd4;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = FETCH;
      FETCH:   if (w_deliver && stall_i) w_state_nxt = HOLD;
      HOLD:    if (w_redirect || !stall_i) w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr;
    w_squash_nxt     = r_squash;
    w_ifid_nxt       = r_ifid;
    w_ifid_valid_nxt = r_ifid_valid;
    w_hold_nxt       = r_hold;

    // without redirect the selector yields pc+4
    if (w_redirect || w_deliver) w_pc_nxt = w_next_pc_c;

    if (w_accept) begin
      w_squash_nxt = 1'b0;
    end else if (w_redirect && (r_state == FETCH)) begin
      w_squash_nxt = 1'b1;
    end

    // an outstanding request keeps its address until it completes
    w_addr_nxt = ((r_state == FETCH) && !imem_ready_i) ? r_addr : w_pc_nxt;

    if (w_deliver && stall_i) w_hold_nxt = '{inst: imem_data_i, pc4: w_pc4};

    if (w_redirect) begin
      w_ifid_nxt.inst  = NOP_INST;
      w_ifid_valid_nxt = 1'b0;
    end else if ((r_state == HOLD) && !stall_i) begin
      w_ifid_nxt       = r_hold;
      w_ifid_valid_nxt = 1'b1;
    end else if (w_deliver && !stall_i) begin
      w_ifid_nxt       = '{inst: imem_data_i, pc4: w_pc4};
      w_ifid_valid_nxt = 1'b1;
    end else if (!stall_i) begin
      w_ifid_nxt.inst  = NOP_INST;
      w_ifid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_squash     <= 1'b0;
      r_req        <= 1'b0;
      r_ifid       <= '{inst: NOP_INST, pc4: '0};
      r_ifid_valid <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_addr       <= w_addr_nxt;
      r_squash     <= w_squash_nxt;
      r_req        <= (w_state_nxt == FETCH);
      r_ifid       <= w_ifid_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_hold       <= w_hold_nxt;
    end
  end

  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_addr;
  assign ifid_inst_o  = r_ifid.inst;
  assign ifid_pc4_o   = r_ifid.pc4;
  assign ifid_valid_o = r_ifid_valid;
  assign op_o         = opcode(r_ifid.inst);

`ifdef FETCH_PERF_EN
  logic        w_fetch_evt;
  logic        w_squash_evt;
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_squash;

  assign w_fetch_evt  = !w_redirect && !stall_i && (((r_state == HOLD)) || w_deliver);
  assign w_squash_evt = (w_accept && (r_squash || w_redirect)) ||
                        ((r_state == HOLD) && w_redirect);

  // saturating event counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perf_fetch  <= '0;
      r_perf_squash <= '0;
    end else begin
      if (w_fetch_evt && (r_perf_fetch != 32'hFFFF_FFFF)) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_squash_evt && (r_perf_squash != 32'hFFFF_FFFF)) r_perf_squash <= r_perf_squash + 32'd1;
    end
  end

  assign perf_fetch_o  = r_perf_fetch;
  assign perf_squash_o = r_perf_squash;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus an in-order fetch scoreboard.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, branch_i, jump_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o, imem_ready_i, ifid_valid_o;
  logic [31:0] imem_addr_o, imem_data_i, ifid_inst_o, ifid_pc4_o;
  logic [5:0]  op_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_squash;
`endif

  logic auto_rdy, rdy_drv;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h1000_0000) return 32'h0800_0010;
    return {16'h8C00, a[15:0]};
  endfunction

  assign imem_ready_i = auto_rdy ? imem_req_o : rdy_drv;
  assign imem_data_i  = mem_word(imem_addr_o);

  fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_data_i     (imem_data_i),
    .ifid_inst_o     (ifid_inst_o),
    .ifid_pc4_o      (ifid_pc4_o),
    .ifid_valid_o    (ifid_valid_o),
    .op_o            (op_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o    (perf_fetch),
    .perf_squash_o   (perf_squash)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        stall, br, jmp;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst, pc4;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst, pc4;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic s, b, j, input logic [31:0] t, input logic r,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] i, p);
    vec_t x;
    x = '{stall: s, br: b, jmp: j, tgt: t, rdy: r, req: q, addr: a, valid: v, inst: i, pc4: p};
    return x;
  endfunction

  task automatic drive_idle();
    start_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
    branch_target_i = 32'h0; rdy_drv = 1'b0; auto_rdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req"},   32'(imem_req_o), 32'h0);
    chk({tag, ".valid"}, 32'(ifid_valid_o), 32'h0);
    chk({tag, ".inst"},  ifid_inst_o, 32'h0);
    chk({tag, ".pc4"},   ifid_pc4_o, 32'h0);
    chk({tag, ".op"},    32'(op_o), 32'h0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] NOP = 32'h0;
    exp_t e;
    drive_idle();
    rst_i = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // redirect while IDLE must be ignored
    branch_i = 1'b1; branch_target_i = 32'h40;
    @(posedge clk_i); #1;
    chk("idle_redirect.req", 32'(imem_req_o), 32'h0);
    @(negedge clk_i);
    branch_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    chk("start.req", 32'(imem_req_o), 32'h1);
    chk("start.addr", imem_addr_o, 32'h0);
    @(negedge clk_i);
    start_i = 1'b0;

    //          stall br jmp tgt            rdy | req addr          valid inst                       pc4
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h4,          1, 32'h2008_0005,              32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h8,          1, mem_word(32'h4),            32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1,  0, 32'h0,          1, mem_word(32'h4),            32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0,  0, 32'h0,          1, mem_word(32'h4),            32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0,  0, 32'h0,          1, mem_word(32'h4),            32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0,  1, 32'hC,          1, mem_word(32'h8),            32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0,  1, 32'hC,          0, NOP,                        32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h40,         0,  1, 32'hC,          0, NOP,                        32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h40,         0, NOP,                        32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h44,         1, mem_word(32'h40),           32'h44));
    tbl.push_back(mk(1, 1, 1, 32'h1000_0000,  1,  1, 32'h1000_0000,  0, NOP,                        32'h44));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h1000_0004,  1, 32'h0800_0010,              32'h1000_0004));
    tbl.push_back(mk(0, 0, 1, 32'h0,          0,  1, 32'h1000_0004,  0, NOP,                        32'h1000_0004));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h1000_0040,  0, NOP,                        32'h1000_0004));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h1000_0044,  1, mem_word(32'h1000_0040),    32'h1000_0044));
    tbl.push_back(mk(0, 1, 0, 32'h1234_5677,  0,  1, 32'h1000_0044,  0, NOP,                        32'h1000_0044));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h1234_5674,  0, NOP,                        32'h1000_0044));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h1234_5678,  1, mem_word(32'h1234_5674),    32'h1234_5678));
    tbl.push_back(mk(0, 1, 0, 32'hFFFF_FFFC,  1,  1, 32'hFFFF_FFFC,  0, NOP,                        32'h1234_5678));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h0,          1, mem_word(32'hFFFF_FFFC),    32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h4,          1, 32'h2008_0005,              32'h4));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1,  0, 32'h0,          1, 32'h2008_0005,              32'h4));
    tbl.push_back(mk(1, 1, 0, 32'h80,         0,  1, 32'h80,         0, NOP,                        32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,  1, 32'h84,         1, mem_word(32'h80),           32'h84));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0,  1, 32'h84,         1, mem_word(32'h80),           32'h84));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0,  1, 32'h84,         0, NOP,                        32'h84));

    foreach (tbl[i]) begin
      stall_i = tbl[i].stall; branch_i = tbl[i].br; jump_i = tbl[i].jmp;
      branch_target_i = tbl[i].tgt; rdy_drv = tbl[i].rdy;
      @(posedge clk_i); #1;
      chk($sformatf("v%0d.req", i), 32'(imem_req_o), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("v%0d.addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("v%0d.valid", i), 32'(ifid_valid_o), 32'(tbl[i].valid));
      chk($sformatf("v%0d.inst", i), ifid_inst_o, tbl[i].inst);
      chk($sformatf("v%0d.pc4", i), ifid_pc4_o, tbl[i].pc4);
      chk($sformatf("v%0d.op", i), 32'(op_o), 32'(tbl[i].inst[31:26]));
      @(negedge clk_i);
    end

    // zero-wait streaming: one instruction per cycle, in address order
    do_reset();
    auto_rdy = 1'b1;
    for (int a = 0; a < 32; a += 4) sb.push_back('{inst: mem_word(32'(a)), pc4: 32'(a + 4)});
    start_i = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (ifid_valid_o) begin
        e = sb.pop_front();
        chk($sformatf("sb%0d.inst", c), ifid_inst_o, e.inst);
        chk($sformatf("sb%0d.pc4", c), ifid_pc4_o, e.pc4);
        chk($sformatf("sb%0d.op", c), 32'(op_o), 32'(e.inst[31:26]));
      end
    end
    auto_rdy = 1'b0; rdy_drv = 1'b0;
    chk("sb.drained", 32'(sb.size()), 32'h0);
    chk("stream.req", 32'(imem_req_o), 32'h1);
    chk("stream.addr", imem_addr_o, 32'h20);

    // reset asserted mid-request at pc 0x20
    @(negedge clk_i);
    chk("wait.addr", imem_addr_o, 32'h20);
    #2 rst_i = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    chk("restart.req", 32'(imem_req_o), 32'h1);
    chk("restart.addr", imem_addr_o, 32'h0);
    start_i = 1'b0; rdy_drv = 1'b1;
    @(posedge clk_i); #1;
    chk("restart.inst", ifid_inst_o, 32'h2008_0005);
    chk("restart.pc4", ifid_pc4_o, 32'h4);
    chk("restart.valid", 32'(ifid_valid_o), 32'h1);
    chk("restart.next_addr", imem_addr_o, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
